// File: rtl/burst_mem_responder.sv
// Four-beat burst memory responder: 256-bit lines moved as 64-bit beats,
// with a configurable read latency and a sticky protocol-error flag.
module burst_mem_responder #(
  parameter int LINE_IDX_W   = 6,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int DEPTH = 4 * (2 ** LINE_IDX_W);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t state, state_nxt;

  logic [LINE_IDX_W-1:0] line_q, line_nxt;
  logic [1:0]            wr_beat_q, wr_beat_nxt;
  logic [2:0]            rd_beat_q, rd_beat_nxt;
  logic [3:0]            lat_cnt_q, lat_cnt_nxt;
  logic [31:0]           raddr_nxt;
  logic                  err_nxt;
  logic                  ready_state;
  logic                  beat_load;
  logic                  mem_we;
  logic [LINE_IDX_W+1:0] mem_waddr;
  logic [LINE_IDX_W-1:0] addr_idx;
  logic                  addr_misaligned;

  logic [63:0] mem [DEPTH];

  assign addr_idx        = bmem_addr[5+LINE_IDX_W-1:5];
  assign addr_misaligned = (bmem_addr[4:0] != 5'd0);

  // Ready is withheld for as long as reset is held, even though the FSM already sits in IDLE.
  assign bmem_ready = ready_state & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_q      <= '0;
      wr_beat_q   <= 2'd0;
      rd_beat_q   <= 3'd0;
      lat_cnt_q   <= 4'd0;
      bmem_raddr  <= 32'd0;
      bmem_rdata  <= 64'd0;
      bmem_rvalid <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_q      <= line_nxt;
      wr_beat_q   <= wr_beat_nxt;
      rd_beat_q   <= rd_beat_nxt;
      lat_cnt_q   <= lat_cnt_nxt;
      bmem_raddr  <= raddr_nxt;
      bmem_rvalid <= beat_load;
      proto_err   <= err_nxt;
      if (beat_load) begin
        bmem_rdata <= mem[{line_q, rd_beat_q[1:0]}];
      end
    end
  end

  // Storage is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= bmem_wdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    line_nxt    = line_q;
    wr_beat_nxt = wr_beat_q;
    rd_beat_nxt = rd_beat_q;
    lat_cnt_nxt = lat_cnt_q;
    raddr_nxt   = bmem_raddr;
    err_nxt     = proto_err;
    ready_state = 1'b0;
    beat_load   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = {line_q, wr_beat_q};

    case (state)
      IDLE: begin
        ready_state = 1'b1;
        if (bmem_read) begin
          raddr_nxt   = {bmem_addr[31:5], 5'd0};
          line_nxt    = addr_idx;
          rd_beat_nxt = 3'd0;
          lat_cnt_nxt = 4'(READ_LATENCY - 1);
          state_nxt   = (READ_LATENCY <= 1) ? RD_DATA : RD_WAIT;
          if (bmem_write || addr_misaligned) begin
            err_nxt = 1'b1;
          end
        end else if (bmem_write) begin
          mem_we      = 1'b1;
          mem_waddr   = {addr_idx, 2'd0};
          line_nxt    = addr_idx;
          wr_beat_nxt = 2'd1;
          state_nxt   = WR;
          if (addr_misaligned) begin
            err_nxt = 1'b1;
          end
        end
      end

      WR: begin
        ready_state = 1'b1;
        if (bmem_read) begin
          err_nxt = 1'b1;
        end
        if (bmem_write) begin
          mem_we = 1'b1;
          if (wr_beat_q == 2'd3) begin
            state_nxt = IDLE;
          end else begin
            wr_beat_nxt = wr_beat_q + 2'd1;
          end
        end
      end

      RD_WAIT: begin
        lat_cnt_nxt = lat_cnt_q - 4'd1;
        if (lat_cnt_q <= 4'd1) begin
          state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        // rd_beat_q counts beats already loaded; 4 means beat 3 is on the bus now.
        if (rd_beat_q == 3'd4) begin
          ready_state = 1'b1;
          state_nxt   = IDLE;
        end else begin
          beat_load   = 1'b1;
          rd_beat_nxt = rd_beat_q + 3'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed and small randomised checks of burst_mem_responder with default parameters.
module tb_burst_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  logic [255:0] model [64];
  int           written_q [$];

  burst_mem_responder #(
    .LINE_IDX_W  (6),
    .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and land 1 time unit after the next rising edge.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [63:0] wdata);
    bmem_read  = rd;
    bmem_write = wr;
    bmem_addr  = addr;
    bmem_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    check_bit("rst ready", bmem_ready, 1'b0);
    check_bit("rst rvalid", bmem_rvalid, 1'b0);
    check_output("rst rdata", bmem_rdata, 64'd0);
    check_output("rst raddr", 64'(bmem_raddr), 64'd0);
    check_bit("rst proto_err", proto_err, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("ready after release", bmem_ready, 1'b1);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [255:0] line, input int stall);
    apply_stimulus(1'b0, 1'b1, addr, line[63:0]);
    apply_stimulus(1'b0, 1'b1, 32'd0, line[127:64]);
    for (int s = 0; s < stall; s++) begin
      apply_stimulus(1'b0, 1'b0, 32'd0, 64'hBAD0_BAD0_BAD0_BAD0);
      check_bit($sformatf("stall %0d ready", s), bmem_ready, 1'b1);
    end
    apply_stimulus(1'b0, 1'b1, 32'd0, line[191:128]);
    apply_stimulus(1'b0, 1'b1, 32'd0, line[255:192]);
    bmem_write = 1'b0;
  endtask

  task automatic read_line(input string tag, input logic [31:0] addr, input logic also_write, input logic [255:0] exp_line);
    logic [31:0] exp_raddr;
    exp_raddr = {addr[31:5], 5'd0};
    apply_stimulus(1'b1, also_write, addr, 64'hFFFF_0000_FFFF_0000);
    check_output({tag, " raddr"}, 64'(bmem_raddr), 64'(exp_raddr));
    for (int i = 0; i < LAT - 1; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
      check_bit($sformatf("%s wait%0d rvalid", tag, i), bmem_rvalid, 1'b0);
      check_bit($sformatf("%s wait%0d ready", tag, i), bmem_ready, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
      check_bit($sformatf("%s beat%0d rvalid", tag, b), bmem_rvalid, 1'b1);
      check_output($sformatf("%s beat%0d rdata", tag, b), bmem_rdata, exp_line[64*b +: 64]);
      check_bit($sformatf("%s beat%0d ready", tag, b), bmem_ready, (b == 3));
    end
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    check_bit({tag, " end rvalid"}, bmem_rvalid, 1'b0);
    check_output({tag, " end rdata hold"}, bmem_rdata, exp_line[255:192]);
    check_bit({tag, " end ready"}, bmem_ready, 1'b1);
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c, line_d, line_e, rnd_line;
    logic [31:0]  rnd, rnd_addr;
    int           idx;

    line_a = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    line_b = {64'hB3B3_0000_1111_2222, 64'hB2B2_3333_4444_5555, 64'hB1B1_6666_7777_8888, 64'hB0B0_9999_AAAA_BBBB};
    line_c = {64'hC000_0000_0000_0003, 64'hC000_0000_0000_0002, 64'hC000_0000_0000_0001, 64'hC000_0000_0000_0000};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_e = {64'hE3E3_0123_4567_89AB, 64'hE2E2_0123_4567_89AB, 64'hE1E1_0123_4567_89AB, 64'hE0E0_0123_4567_89AB};

    rst_n      = 1'b0;
    bmem_addr  = 32'd0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = 64'd0;
    $display("[TB] start");

    do_reset();

    write_line(32'h0000_0100, line_a, 0);
    read_line("raw", 32'h0000_0100, 1'b0, line_a);

    write_line(32'h0000_0200, line_b, 2);
    read_line("stall", 32'h0000_0200, 1'b0, line_b);

    write_line(32'h0000_0040, line_c, 0);
    read_line("wrap", 32'h0000_0840, 1'b0, line_c);
    check_bit("wrap proto_err", proto_err, 1'b0);

    write_line(32'h0000_0020, line_d, 0);
    read_line("rdwr", 32'h0000_0020, 1'b1, line_d);
    check_bit("rdwr proto_err", proto_err, 1'b1);
    read_line("misalign", 32'h0000_0024, 1'b0, line_d);
    check_bit("sticky proto_err", proto_err, 1'b1);

    // Reset while beat 1 of a read is on the bus.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 32'h0000_0100, 64'd0);
    for (int i = 0; i < LAT - 1; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    check_output("abort beat1 rdata", bmem_rdata, line_a[127:64]);
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    check_bit("abort rvalid", bmem_rvalid, 1'b0);
    check_bit("abort ready", bmem_ready, 1'b0);
    check_output("abort rdata", bmem_rdata, 64'd0);
    rst_n = 1'b1;
    #1;
    check_bit("abort release ready", bmem_ready, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 64'd0);
    check_bit("abort no late rvalid", bmem_rvalid, 1'b0);
    read_line("post abort", 32'h0000_0100, 1'b0, line_a);
    check_bit("post abort proto_err", proto_err, 1'b0);

    // A read raised during a write burst is ignored but flagged.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0300, line_e[63:0]);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0100, 64'd0);
    check_bit("wr read ready", bmem_ready, 1'b1);
    check_bit("wr read rvalid", bmem_rvalid, 1'b0);
    check_bit("wr read proto_err", proto_err, 1'b1);
    apply_stimulus(1'b0, 1'b1, 32'd0, line_e[127:64]);
    apply_stimulus(1'b0, 1'b1, 32'd0, line_e[191:128]);
    apply_stimulus(1'b0, 1'b1, 32'd0, line_e[255:192]);
    read_line("wr read", 32'h0000_0300, 1'b0, line_e);

    do_reset();
    for (int n = 0; n < 24; n++) begin
      rnd = $urandom();
      idx = int'($urandom_range(0, 63));
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        rnd_line = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rnd_addr = {rnd[31:11], 6'(idx), 5'd0};
        write_line(rnd_addr, rnd_line, int'($urandom_range(0, 1)));
        model[idx] = rnd_line;
        written_q.push_back(idx);
      end else begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        rnd_addr = {rnd[31:11], 6'(idx), 5'd0};
        read_line($sformatf("rand%0d", n), rnd_addr, 1'b0, model[idx]);
      end
    end
    check_bit("rand proto_err", proto_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
